// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-store memory responder with programmable read/write latency
module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // The array is deliberately left out of reset.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Request as seen on the cycle that enters RESP: live inputs when a
  // zero-latency request goes straight from IDLE, latched copy otherwise.
  logic                eff_we;
  logic [ADDR_W-1:0]   eff_addr;
  logic [DATA_W-1:0]   eff_wdata;
  logic                enter_resp;
  logic [3:0]          lat_sel;
  logic                mem_we;

  // Next-state, request latching and response data selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    eff_we     = we_q;
    eff_addr   = addr_q;
    eff_wdata  = wdata_q;
    enter_resp = 1'b0;
    lat_sel    = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          eff_we    = req_we;
          eff_addr  = req_addr;
          eff_wdata = req_wdata;
          lat_sel   = req_we ? WR_L : RD_L;
          cnt_d     = lat_sel;
          if (lat_sel == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (enter_resp) begin
      rdata_d = eff_we ? eff_wdata : mem_q[eff_addr];
    end
  end

  // A write commits only on a clean edge into RESP; reset drops it.
  assign mem_we = enter_resp & eff_we & ~rst;

  // State, counter, latched request and response data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array write port, committed on entry to RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[eff_addr] <= eff_wdata;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign dbg_rdata  = mem_q[dbg_addr];

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;
  localparam int RDL [N] = '{2, 0, 5};
  localparam int WRL [N] = '{1, 0, 3};

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid  [N];
  logic          req_ready  [N];
  logic          req_we     [N];
  logic [AW-1:0] req_addr   [N];
  logic [DW-1:0] req_wdata  [N];
  logic          resp_valid [N];
  logic [DW-1:0] resp_rdata [N];
  logic          busy       [N];
  logic [AW-1:0] dbg_addr   [N];
  logic [DW-1:0] dbg_rdata  [N];

  // Reference store: what each instance's array must hold.
  logic [DW-1:0] model_mem [N][DEPTH];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL[g]), .WR_LAT(WRL[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .busy      (busy[g]),
      .dbg_addr  (dbg_addr[g]),
      .dbg_rdata (dbg_rdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: expected latency is LAT+1, data comes from the model.
  task automatic txn(input int k, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input bit noise);
    int lat;
    int cyc;
    logic [DW-1:0] exp;
    lat = we ? WRL[k] : RDL[k];
    exp = we ? wdata : model_mem[k][addr];
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    dbg_addr[k]  = addr;
    #1;
    chk("idle_ready", 32'(req_ready[k]), 1);
    chk("idle_busy", 32'(busy[k]), 0);
    chk("dbg_before", dbg_rdata[k], model_mem[k][addr]);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        req_addr[k]  = AW'($urandom);
        req_wdata[k] = $urandom;
        req_we[k]    = 1'($urandom);
      end else begin
        req_valid[k] = 1'b0;
      end
      #1;
      if (resp_valid[k]) break;
      chk("wait_busy", 32'(busy[k]), 1);
      chk("wait_ready", 32'(req_ready[k]), 0);
    end
    chk("latency", cyc, lat + 1);
    chk("resp_rdata", resp_rdata[k], exp);
    chk("resp_busy", 32'(busy[k]), 1);
    if (we) begin
      model_mem[k][addr] = wdata;
      chk("dbg_commit", dbg_rdata[k], wdata);
    end
    req_valid[k] = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] old;
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < DEPTH; a++) model_mem[k][a] = '0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      dbg_addr[k]  = '0;
    end
    rst = 1'b1;
    #2;
    for (int k = 0; k < N; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 1);
      chk("rst_resp_valid", 32'(resp_valid[k]), 0);
      chk("rst_busy", 32'(busy[k]), 0);
      chk("rst_rdata", resp_rdata[k], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write then read back, RD_LAT=2 / WR_LAT=1.
    txn(0, 1'b1, 10'h005, 32'h1234_5678, 1'b0);
    txn(0, 1'b0, 10'h005, '0, 1'b0);

    // Traffic while busy is ignored; the follow-up is accepted on first IDLE.
    txn(0, 1'b1, 10'h010, 32'h0BAD_F00D, 1'b1);
    txn(0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0);
    txn(0, 1'b0, 10'h010, '0, 1'b0);

    // Boundary addresses with no aliasing.
    txn(0, 1'b1, 10'h000, 32'hAAAA_AAAA, 1'b0);
    txn(0, 1'b1, 10'h3FF, 32'h5555_5555, 1'b0);
    txn(0, 1'b0, 10'h000, '0, 1'b0);
    txn(0, 1'b0, 10'h3FF, '0, 1'b0);

    // Zero latency: req_valid held high, one acceptance every 2 cycles.
    for (int i = 0; i < 4; i++) txn(1, 1'b1, AW'(i), $urandom, 1'b0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[1] = AW'(i);
      #1;
      chk("b2b_ready", 32'(req_ready[1]), 1);
      chk("b2b_idle_valid", 32'(resp_valid[1]), 0);
      @(negedge clk);
      if (i == 3) req_valid[1] = 1'b0;
      #1;
      chk("b2b_resp_valid", 32'(resp_valid[1]), 1);
      chk("b2b_rdata", resp_rdata[1], model_mem[1][i]);
      chk("b2b_busy", 32'(req_ready[1]), 0);
      @(negedge clk);
    end

    // Randomized traffic across all latency configurations.
    for (int t = 0; t < 60; t++) begin
      int k;
      logic [AW-1:0] a;
      k = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? '1 : '0;
      else a = AW'($urandom_range(0, 31));
      txn(k, 1'($urandom), a, $urandom, $urandom_range(0, 3) == 0);
    end

    // Reset during a pending write (WR_LAT=3) drops it.
    txn(2, 1'b1, 10'h3FF, 32'h1357_9BDF, 1'b0);
    old = model_mem[2][10'h3FF];
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 10'h3FF;
    req_wdata[2] = 32'hCAFE_F00D;
    dbg_addr[2]  = 10'h3FF;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy[2]), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready[2]), 1);
    chk("mid_rst_busy", 32'(busy[2]), 0);
    chk("mid_rst_valid", 32'(resp_valid[2]), 0);
    chk("mid_rst_rdata", resp_rdata[2], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", 32'(resp_valid[2]), 0);
    end
    chk("post_rst_dbg", dbg_rdata[2], old);
    txn(2, 1'b0, 10'h3FF, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
